cla_chunk_sequencer: RTL and testbench
======================================

# cla_chunk_sequencer

Multi-cycle wide adder controller that computes WIDTH-bit a + b + cin by sequencing one shared 4-bit carry-lookahead slice over WIDTH/4 cycles. Operands arrive on a valid/ready request port. The block steps the slice nibble by nibble, least significant first, and holds a registered inter-chunk carry between steps. The result leaves on a valid/ready response port. It lets wide additions in the design reuse the existing 4-bit CLA instead of instantiating a wide combinational adder.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4 (elaboration error otherwise)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request operands valid
- in_ready  out  1  block can accept a request (high only in IDLE)
- a  in  WIDTH  addend A, sampled on request handshake
- b  in  WIDTH  addend B, sampled on request handshake
- cin  in  1  carry-in, sampled on request handshake
- out_valid  out  1  result valid (high only in DONE)
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  registered result (a + b + cin) mod 2^WIDTH
- cout  out  1  registered carry out of bit WIDTH-1
- busy  out  1  high in RUN or DONE

## Operation
- NCHUNK = WIDTH/4. Chunk counter is $clog2(NCHUNK)+1 bits wide, so WIDTH=4 needs no special case.
- State machine has three states, IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, load a and b into operand shift registers, set carry_q=cin, idx=0, clear the result register, and go to RUN.
- RUN:
  - Each cycle the CLA slice receives the low nibbles of both operand shift registers plus carry_q.
  - On the edge, the slice sum nibble is shifted into the result register from the top (result shifts right by 4).
  - On the same edge, both operand registers shift right by 4 and carry_q takes the slice cout.
  - idx increments each step.
  - After the step with idx==NCHUNK-1, go to DONE. cout takes that step's slice carry and sum takes the completed result.
- DONE:
  - out_valid=1, and sum/cout are held stable.
  - On out_ready, go to IDLE.
  - No new request is accepted in DONE, even if in_valid and out_ready are both high; it is accepted the following cycle in IDLE.
- Inputs a, b and cin are ignored outside the accept edge, so changing them during RUN has no effect.
- Reset, including mid-RUN or mid-DONE:
  - State goes to IDLE immediately and the in-flight operation is discarded.
  - sum=0, cout=0, out_valid=0, busy=0, in_ready=1.
  - Operand, carry and idx registers are cleared to 0.
- Width rule: the result is exactly the low WIDTH bits of the true sum, and cout is bit WIDTH. No saturation and no overflow flag for signed use.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, sum=0, cout=0.
- Latency: with the request accepted at edge E0, out_valid rises after edge E0+NCHUNK (4 cycles for WIDTH=16, 1 for WIDTH=4).
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held high.
- in_ready falls in the cycle after acceptance and stays low until the cycle after the response handshake.
- Backpressure: with out_ready low, DONE is held indefinitely and sum/cout/out_valid do not change.
- busy rises with the accept edge and falls with the response handshake edge.
- Combinational path per cycle is one 4-bit CLA slice plus the register setup time. There is no combinational path from in_* to out_*.

## Structure
- Shared package cla_seq_pkg contains:
  - CHUNK_W=4;
  - the state enum {IDLE, RUN, DONE};
  - a function returning NCHUNK from WIDTH.
- Exactly one sub-module: the existing fourbitcla_claudelow slice, instantiated once (ports a, b, cin, sum, cout), driven from the shift-register low nibbles and carry_q.
- Everything else is local to cla_chunk_sequencer: FSM, counter, operand/result shift registers, carry register.

## Test plan
- WIDTH=16: a=16'hFFFF, b=16'h0001, cin=0 -> sum=16'h0000, cout=1; out_valid exactly 4 cycles after accept.
- WIDTH=16: a=16'h1234, b=16'h4321, cin=1 -> sum=16'h5556, cout=0. Then a=16'hA5A5, b=16'h5A5A, cin=1 -> sum=16'h0000, cout=1 (carry ripples through every chunk).
- Backpressure: a=16'h8000, b=16'h8000, cin=0, with out_ready held low 5 cycles in DONE:
  - required: sum=16'h0000, cout=1, out_valid=1 stable, in_ready=0, busy=1;
  - release out_ready -> IDLE next cycle.
- Reset mid-RUN: assert rst_n=0 after 2 chunk steps:
  - required: all outputs immediately at reset values;
  - next request a=16'h00FF, b=16'h0001, cin=0 -> sum=16'h0100, cout=0.
- Back-to-back with out_ready=1 and in_valid=1 held: 3 random operations match the reference model, each spaced exactly NCHUNK+2 cycles apart; a, b and cin changed during RUN do not affect the result.
- WIDTH=4: a=4'hF, b=4'hF, cin=1 -> sum=4'hF, cout=1 with 1-cycle latency; a=0, b=0, cin=0 -> sum=0, cout=0.

Source files
------------

// File: rtl/cla_chunk_sequencer_pkg.sv
// Shared definitions for the chunked carry-lookahead adder sequencer.
package cla_seq_pkg;

  localparam int unsigned CHUNK_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Number of CHUNK_W-bit slice steps needed for a WIDTH-bit operand.
  function automatic int unsigned nchunk(input int unsigned width);
    return width / CHUNK_W;
  endfunction

endpackage

// File: rtl/cla_chunk_sequencer_slice.sv
// Existing 4-bit carry-lookahead adder slice.
module fourbitcla_claudelow (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/cla_chunk_sequencer.sv
// Wide adder that reuses one 4-bit CLA slice over WIDTH/4 cycles,
// least significant nibble first, with valid/ready request and response.
module cla_chunk_sequencer
  import cla_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned NCHUNK = nchunk(WIDTH);
  localparam int unsigned IDX_W  = $clog2(NCHUNK) + 1;

  if ((WIDTH % CHUNK_W) != 0 || WIDTH < CHUNK_W) begin : g_bad_width
    $error("cla_chunk_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   res_q;
  logic [WIDTH-1:0]   res_d;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic [IDX_W-1:0]   idx_q;
  logic [CHUNK_W-1:0] slice_sum;
  logic               slice_cout;

  fourbitcla_claudelow u_slice (
    .a    (a_q[CHUNK_W-1:0]),
    .b    (b_q[CHUNK_W-1:0]),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Result register shifts right by one nibble, new slice nibble enters at the top.
  if (WIDTH == CHUNK_W) begin : g_res_single
    always_comb res_d = slice_sum;
  end else begin : g_res_multi
    always_comb res_d = {slice_sum, res_q[WIDTH-1:CHUNK_W]};
  end

  // Control FSM, operand/result shift registers, carry and chunk counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
            res_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> CHUNK_W;
          b_q     <= b_q >> CHUNK_W;
          carry_q <= slice_cout;
          res_q   <= res_d;
          idx_q   <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NCHUNK - 1)) begin
            sum_q   <= res_d;
            cout_q  <= slice_cout;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_cla_chunk_sequencer.sv
// Scoreboard bench for cla_chunk_sequencer at WIDTH=16 and WIDTH=4.
module tb_cla_chunk_sequencer;

  localparam int unsigned NCH16 = 4;
  localparam int unsigned NCH4  = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, out_valid, out_ready, cin, cout, busy;
  logic [15:0] a, b, sum;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, cin4, cout4, busy4;
  logic [3:0]  a4, b4, sum4;

  cla_chunk_sequencer #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  cla_chunk_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .a(a4), .b(b4), .cin(cin4), .out_valid(out_valid4), .out_ready(out_ready4),
    .sum(sum4), .cout(cout4), .busy(busy4)
  );

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [16:0] res;   // {carry, sum} of the true addition
    int unsigned acc;   // cycle count after the accept edge
  } exp_t;

  exp_t        q16[$];
  exp_t        q4[$];
  int unsigned acc16[$];
  bit          ov16_prev = 1'b0;
  bit          ov4_prev  = 1'b0;

  // WIDTH=16: capture accepted requests into the model, check responses.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid && in_ready) begin
        e.res = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        e.acc = cyc + 1;
        q16.push_back(e);
        acc16.push_back(cyc + 1);
      end
      if (out_valid && !ov16_prev) begin
        checks++;
        if (q16.size() == 0) begin
          errors++;
          $display("FAIL resp16_unexpected: out_valid with no outstanding request");
        end else begin
          checks--;
          chk("latency16", cyc - q16[0].acc, NCH16);
        end
      end
      if (out_valid && out_ready && q16.size() != 0) begin
        e = q16.pop_front();
        chk("sum16", {16'b0, sum}, {16'b0, e.res[15:0]});
        chk("cout16", {31'b0, cout}, {31'b0, e.res[16]});
      end
    end
    ov16_prev = out_valid;
  end

  // WIDTH=4: same scoreboard scheme.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (in_valid4 && in_ready4) begin
        e.res = {13'b0, a4} + {13'b0, b4} + {16'b0, cin4};
        e.acc = cyc + 1;
        q4.push_back(e);
      end
      if (out_valid4 && !ov4_prev) begin
        checks++;
        if (q4.size() == 0) begin
          errors++;
          $display("FAIL resp4_unexpected: out_valid with no outstanding request");
        end else begin
          checks--;
          chk("latency4", cyc - q4[0].acc, NCH4);
        end
      end
      if (out_valid4 && out_ready4 && q4.size() != 0) begin
        e = q4.pop_front();
        chk("sum4", {28'b0, sum4}, {28'b0, e.res[3:0]});
        chk("cout4", {31'b0, cout4}, {31'b0, e.res[4]});
      end
    end
    ov4_prev = out_valid4;
  end

  task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic c);
    bit ok = 1'b0;
    a = av; b = bv; cin = c; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    chk("accept16", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send4(input logic [3:0] av, input logic [3:0] bv, input logic c);
    bit ok = 1'b0;
    a4 = av; b4 = bv; cin4 = c; in_valid4 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready4) begin ok = 1'b1; break; end
    end
    chk("accept4", {31'b0, ok}, 32'd1);
    @(posedge clk); #1;
    in_valid4 = 1'b0;
  endtask

  task automatic drain;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (q16.size() == 0 && q4.size() == 0 && in_ready && in_ready4) break;
    end
    chk("drain16", q16.size(), 0);
    chk("drain4", q4.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n0;
    bit ok;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid4 = 1'b0; out_ready4 = 1'b1; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sum", {16'b0, sum}, 32'd0);
    chk("rst_cout", {31'b0, cout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    send16(16'hFFFF, 16'h0001, 1'b0);
    drain();
    send16(16'hA5A5, 16'h5A5A, 1'b1);
    drain();

    // Backpressure: result held in DONE while out_ready is low.
    out_ready = 1'b0;
    send16(16'h8000, 16'h8000, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("bp_valid_seen", {31'b0, ok}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i != 0) @(negedge clk);
      chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_sum", {16'b0, sum}, 32'h0000);
      chk("bp_cout", {31'b0, cout}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_busy", {31'b0, busy}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
    chk("bp_release_busy", {31'b0, busy}, 32'd0);
    chk("bp_release_out_valid", {31'b0, out_valid}, 32'd0);

    send16(16'h1234, 16'h4321, 1'b1);
    drain();

    // Reset after two chunk steps of an in-flight operation.
    send16(16'hFFFF, 16'hFFFF, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    q16.delete();
    #1;
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_sum", {16'b0, sum}, 32'd0);
    chk("midrst_cout", {31'b0, cout}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send16(16'h00FF, 16'h0001, 1'b0);
    drain();

    // Back-to-back with in_valid held and operands changing every cycle.
    n0 = acc16.size();
    out_ready = 1'b1;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
      if (acc16.size() >= n0 + 3) break;
    end
    in_valid = 1'b0;
    chk("b2b_accepts", acc16.size() - n0, 3);
    if (acc16.size() >= n0 + 3) begin
      chk("b2b_gap1", acc16[n0+1] - acc16[n0], NCH16 + 2);
      chk("b2b_gap2", acc16[n0+2] - acc16[n0+1], NCH16 + 2);
    end
    drain();

    // WIDTH=4 instance.
    send4(4'hF, 4'hF, 1'b1);
    drain();
    chk("w4_sum_direct", {28'b0, sum4}, 32'hF);
    chk("w4_cout_direct", {31'b0, cout4}, 32'd1);
    send4(4'h0, 4'h0, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) begin
      send4(4'($urandom), 4'($urandom), 1'($urandom));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
